// File: rtl/cpu_step_ctrl.sv
// Single-step / run / halt controller for a teaching CPU.
// Two debounced push buttons drive a small FSM that gates the CPU clock enable.

module cpu_step_db #(
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic press
);

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic        db;
    logic        db_d;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= 16'd0;
            press <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            if (sync2 == db) begin
                cnt <= 16'd0;
            end else if (cnt == DB_LAST) begin
                db  <= sync2;
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

module cpu_step_ctrl #(
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        halt,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [1:0] {
        PAUSE  = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   step_press;
    logic   run_press;

    cpu_step_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .pin   (btn_step),
        .press (step_press)
    );

    cpu_step_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .pin   (btn_run),
        .press (run_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= PAUSE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Run beats step in PAUSE; halt beats run in RUN.
    always_comb begin
        nxt_state = cur_state;
        cpu_en    = 1'b0;
        unique case (cur_state)
            PAUSE: begin
                if (run_press) begin
                    nxt_state = RUN;
                end else if (step_press) begin
                    nxt_state = STEP;
                end
            end
            STEP: begin
                cpu_en    = 1'b1;
                nxt_state = halt ? HALTED : PAUSE;
            end
            RUN: begin
                cpu_en = 1'b1;
                if (halt) begin
                    nxt_state = HALTED;
                end else if (run_press) begin
                    nxt_state = PAUSE;
                end
            end
            HALTED: begin
                nxt_state = HALTED;
            end
            default: begin
                nxt_state = PAUSE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 16'd0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a short debounce window (DB_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        btn_run;
    logic        halt;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_step_ctrl #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_run   (btn_run),
        .halt      (halt),
        .cpu_en    (cpu_en),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // One rising edge, then wait to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        btn_step = 1'b0;
        btn_run  = 1'b0;
        halt     = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        do_reset();
        n_cmp++;
        if (state !== 2'd0 || cpu_en !== 1'b0 || cycle_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: state=%0d en=%0b cnt=%0d want 0/0/0",
                     state, cpu_en, cycle_cnt);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (state !== 2'd0 || cpu_en !== 1'b0 || cycle_cnt !== 16'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle_100: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_step_hold();
        int pulses;
        int width;
        int maxw;
        pulses = 0;
        width  = 0;
        maxw   = 0;
        do_reset();
        btn_step = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 20) btn_step = 1'b0;
            if (t == 7) begin
                n_cmp++;
                if (state !== 2'd0) begin
                    n_bad++;
                    $display("FAIL step_lat_early: state=%0d want 0", state);
                end
            end
            if (t == 8) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_bad++;
                    $display("FAIL step_lat: state=%0d want 1", state);
                end
            end
            if (cpu_en === 1'b1) begin
                if (width == 0) pulses++;
                width++;
                if (width > maxw) maxw = width;
            end else begin
                width = 0;
            end
        end
        n_cmp++;
        if (pulses != 1 || maxw != 1) begin
            n_bad++;
            $display("FAIL step_pulse: pulses=%0d width=%0d want 1/1", pulses, maxw);
        end
        n_cmp++;
        if (cycle_cnt !== 16'd1 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL step_end: cnt=%0d state=%0d want 1/0", cycle_cnt, state);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        do_reset();
        btn_step = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 3) btn_step = 1'b0;
            if (state !== 2'd0 || cpu_en !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || cycle_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL glitch: bad=%0d cnt=%0d want 0/0", bad, cycle_cnt);
        end
    endtask

    task automatic test_run_pause();
        int run_cycles;
        int en_bad;
        run_cycles = 0;
        en_bad     = 0;
        do_reset();
        btn_run = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (state === 2'd2) run_cycles++;
            if (cpu_en !== (state == 2'd2)) en_bad++;
            if (t == 10) btn_run = 1'b0;
            if (t == 20) btn_step = 1'b1;
            if (t == 30) btn_step = 1'b0;
            if (t == 50) btn_run = 1'b1;
            if (t == 60) btn_run = 1'b0;
        end
        n_cmp++;
        if (run_cycles != 50) begin
            n_bad++;
            $display("FAIL run_len: got %0d want 50", run_cycles);
        end
        n_cmp++;
        if (en_bad != 0) begin
            n_bad++;
            $display("FAIL run_en: %0d bad cycles want 0", en_bad);
        end
        n_cmp++;
        if (cycle_cnt !== 16'd50 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL run_end: cnt=%0d state=%0d want 50/0", cycle_cnt, state);
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        do_reset();
        halt = 1'b1;
        tick();
        tick();
        halt = 1'b0;
        n_cmp++;
        if (state !== 2'd0) begin
            n_bad++;
            $display("FAIL halt_in_pause: state=%0d want 0", state);
        end
        btn_run = 1'b1;
        for (int t = 1; t <= 10; t++) tick();
        btn_run = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_cmp++;
        if (state !== 2'd3 || cpu_en !== 1'b0 || cycle_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL halt_enter: state=%0d en=%0b cnt=%0d want 3/0/3",
                     state, cpu_en, cycle_cnt);
        end
        for (int t = 1; t <= 60; t++) begin
            if (t == 10) btn_run = 1'b1;
            if (t == 20) btn_run = 1'b0;
            if (t == 30) btn_step = 1'b1;
            if (t == 40) btn_step = 1'b0;
            halt = (t == 45);
            tick();
            if (state !== 2'd3 || cpu_en !== 1'b0 || cycle_cnt !== 16'd3) bad++;
        end
        halt = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL halt_hold: %0d bad cycles want 0", bad);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (state !== 2'd0 || cycle_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL halt_reset: state=%0d cnt=%0d want 0/0", state, cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        btn_step = 1'b1;
        for (int t = 1; t <= 4; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 7) begin
                n_cmp++;
                if (state !== 2'd0) begin
                    n_bad++;
                    $display("FAIL rst_hold_early: state=%0d want 0", state);
                end
            end
        end
        n_cmp++;
        if (state !== 2'd1) begin
            n_bad++;
            $display("FAIL rst_hold_press: state=%0d want 1", state);
        end
        btn_step = 1'b0;
        for (int t = 1; t <= 15; t++) tick();
    endtask

    task automatic test_wrap_and_both();
        do_reset();
        btn_run = 1'b1;
        for (int t = 1; t <= 65570; t++) begin
            tick();
            if (t == 10) btn_run = 1'b0;
            if (t == 65537) btn_run = 1'b1;
            if (t == 65547) btn_run = 1'b0;
            if (t == 65542) begin
                n_cmp++;
                if (cycle_cnt !== 16'hFFFE) begin
                    n_bad++;
                    $display("FAIL wrap_pre: cnt=%h want fffe", cycle_cnt);
                end
            end
            if (t == 65545) begin
                n_cmp++;
                if (cycle_cnt !== 16'h0001 || state !== 2'd0) begin
                    n_bad++;
                    $display("FAIL wrap_post: cnt=%h state=%0d want 0001/0",
                             cycle_cnt, state);
                end
            end
        end
        btn_run  = 1'b1;
        btn_step = 1'b1;
        for (int t = 1; t <= 8; t++) tick();
        n_cmp++;
        if (state !== 2'd2) begin
            n_bad++;
            $display("FAIL both_press: state=%0d want 2", state);
        end
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        btn_step = 1'b0;
        btn_run  = 1'b0;
        halt     = 1'b0;
        test_reset();
        test_step_hold();
        test_glitch();
        test_run_pause();
        test_halt();
        test_reset_mid_debounce();
        test_wrap_and_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
